// File: rtl/ingress_frame_buffer.sv
// ingress_frame_buffer: stores qualified ingress frames in a single-clock FIFO
// and releases a frame to the egress AXI-stream only after its last word is
// stored. A frame that is dropped, truncated or overflows is rolled back to the
// last commit point. Egress uses a one-word prefetch register in front of the
// RAM so a frame streams without bubbles while tready stays high.
// Optional drop/overflow statistics: define PACKET_FILTER_BUFFER_STATS_EN.

package ingress_frame_buffer_pkg;

    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic        tlast;
    } axis_source_t;

    typedef struct packed {
        logic tready;
    } axis_sink_t;

    typedef struct packed {
        logic scan_preamble;
        logic scan_sfd;
        logic scan_dst_mac;
        logic scan_src_mac;
        logic scan_type;
        logic scan_payload;
    } frame_status;

endpackage

module ingress_frame_buffer
    import ingress_frame_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned AF_MARGIN = 768
) (
    input  logic                    clk,
    input  logic                    reset,
    input  axis_source_t            ingress_pkt,
    input  logic                    ingress_accept,
    input  frame_status             status,
    input  logic                    incomplete_frame,
    input  logic                    drop_current,
    output logic                    almost_full,
    output axis_source_t            egress_source,
    input  axis_sink_t              egress_sink,
    output logic [$clog2(DEPTH):0]  frame_count,
    output logic [15:0]             drop_count,
    output logic [15:0]             overflow_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t FULL_WORDS = ptr_t'(DEPTH);
    localparam ptr_t AF_WORDS   = ptr_t'(AF_MARGIN);
    localparam ptr_t PTR_ONE    = ptr_t'(1);

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        DISCARD
    } wr_state_e;

    // Storage: 16 data bits plus tlast in bit 16
    logic [16:0] mem [DEPTH];

    wr_state_e    state_q, state_d;
    ptr_t         wr_ptr_q, wr_ptr_d;
    ptr_t         commit_ptr_q, commit_ptr_d;
    ptr_t         rd_ptr_q, rd_ptr_d;
    ptr_t         fe_ptr_q, fe_ptr_d;
    axis_source_t out_q, out_d;
    ptr_t         fc_q, fc_d;
    logic         af_q, af_d;

    logic         word_ok;
    logic         last_acc;
    logic         in_frame;
    logic         mem_we;
    logic         commit;
    logic         drop_evt;
    logic         ovf_evt;
    ptr_t         used;
    logic         eg_hs;
    logic         eg_last;
    logic         fetch;
    logic [16:0]  rd_word;

    // Preamble/SFD words carry none of the field-scan flags and are never stored
    assign word_ok  = ingress_accept && ingress_pkt.tvalid &&
                      (status.scan_dst_mac || status.scan_src_mac ||
                       status.scan_type    || status.scan_payload);
    assign last_acc = ingress_accept && ingress_pkt.tlast;
    assign in_frame = (state_q == STORE) || ((state_q == IDLE) && word_ok);

    // Occupancy counts the word held in the egress register until its handshake
    assign used = wr_ptr_q - rd_ptr_q;

    logic unused_status;
    assign unused_status = status.scan_preamble | status.scan_sfd;

    // Write FSM: store, commit on tlast, roll back on drop/truncation/overflow
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        commit       = 1'b0;
        drop_evt     = 1'b0;
        ovf_evt      = 1'b0;
        case (state_q)
            IDLE, STORE: begin
                if (in_frame) begin
                    if (incomplete_frame) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_evt = 1'b1;
                        state_d  = IDLE;
                    end else if (drop_current) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_evt = 1'b1;
                        state_d  = last_acc ? IDLE : DISCARD;
                    end else if (word_ok) begin
                        if (used == FULL_WORDS) begin
                            wr_ptr_d = commit_ptr_q;
                            ovf_evt  = 1'b1;
                            state_d  = ingress_pkt.tlast ? IDLE : DISCARD;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            if (ingress_pkt.tlast) begin
                                commit_ptr_d = wr_ptr_q + PTR_ONE;
                                commit       = 1'b1;
                                state_d      = IDLE;
                            end else begin
                                state_d = STORE;
                            end
                        end
                    end
                end
            end
            DISCARD: begin
                if (last_acc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {ingress_pkt.tlast, ingress_pkt.tdata};
        end
    end

    assign rd_word = mem[fe_ptr_q[AW-1:0]];
    assign eg_hs   = out_q.tvalid && egress_sink.tready;
    assign eg_last = eg_hs && out_q.tlast;
    // Refill the egress register whenever it is empty or being drained this cycle
    assign fetch   = (fe_ptr_q != commit_ptr_q) && (!out_q.tvalid || egress_sink.tready);

    // Egress prefetch register and read/fetch pointer advance
    always_comb begin
        out_d    = out_q;
        rd_ptr_d = rd_ptr_q;
        fe_ptr_d = fe_ptr_q;
        if (eg_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (fetch) begin
            fe_ptr_d     = fe_ptr_q + PTR_ONE;
            out_d.tvalid = 1'b1;
            out_d.tdata  = rd_word[15:0];
            out_d.tlast  = rd_word[16];
        end else if (eg_hs) begin
            out_d.tvalid = 1'b0;
        end
    end

    // Committed-frame count and registered almost-full flag
    always_comb begin
        fc_d = fc_q;
        case ({commit, eg_last})
            2'b10:   fc_d = fc_q + PTR_ONE;
            2'b01:   fc_d = fc_q - PTR_ONE;
            default: fc_d = fc_q;
        endcase
        af_d = (FULL_WORDS - used) < AF_WORDS;
    end

    // State and pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            fe_ptr_q     <= '0;
            out_q        <= '0;
            fc_q         <= '0;
            af_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fe_ptr_q     <= fe_ptr_d;
            out_q        <= out_d;
            fc_q         <= fc_d;
            af_q         <= af_d;
        end
    end

    assign egress_source = out_q;
    assign frame_count   = fc_q;
    assign almost_full   = af_q;

`ifdef PACKET_FILTER_BUFFER_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating statistics next-state
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (drop_evt && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (ovf_evt && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign drop_count     = drop_cnt_q;
    assign overflow_count = ovf_cnt_q;
`else
    logic unused_stat_evt;
    assign unused_stat_evt = drop_evt | ovf_evt;
    assign drop_count      = '0;
    assign overflow_count  = '0;
`endif

endmodule

// File: tb/tb_ingress_frame_buffer.sv
// Directed testbench for ingress_frame_buffer (default parameters).
// Statistics expectations follow PACKET_FILTER_BUFFER_STATS_EN.

module tb_ingress_frame_buffer;
    import ingress_frame_buffer_pkg::*;

`ifdef PACKET_FILTER_BUFFER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam frame_status ST_NONE = '0;
    localparam frame_status ST_PRE  = '{scan_preamble: 1'b1, default: 1'b0};
    localparam frame_status ST_SFD  = '{scan_sfd: 1'b1, default: 1'b0};
    localparam frame_status ST_DST  = '{scan_dst_mac: 1'b1, default: 1'b0};
    localparam frame_status ST_PAY  = '{scan_payload: 1'b1, default: 1'b0};

    logic         clk = 1'b0;
    logic         reset;
    axis_source_t ingress_pkt;
    logic         ingress_accept;
    frame_status  status;
    logic         incomplete_frame;
    logic         drop_current;
    logic         almost_full;
    axis_source_t egress_source;
    axis_sink_t   egress_sink;
    logic [11:0]  frame_count;
    logic [15:0]  drop_count;
    logic [15:0]  overflow_count;

    int checks = 0;
    int passed = 0;

    logic [16:0] eg_q[$];
    int          eg_cyc[$];
    int          cyc = 0;

    always #5 clk = ~clk;

    ingress_frame_buffer #(.DEPTH(2048), .AF_MARGIN(768)) dut (
        .clk              (clk),
        .reset            (reset),
        .ingress_pkt      (ingress_pkt),
        .ingress_accept   (ingress_accept),
        .status           (status),
        .incomplete_frame (incomplete_frame),
        .drop_current     (drop_current),
        .almost_full      (almost_full),
        .egress_source    (egress_source),
        .egress_sink      (egress_sink),
        .frame_count      (frame_count),
        .drop_count       (drop_count),
        .overflow_count   (overflow_count)
    );

    // Egress monitor: records every handshake word and its cycle number
    always @(posedge clk) begin
        cyc++;
        if (reset && egress_source.tvalid && egress_sink.tready) begin
            eg_q.push_back({egress_source.tlast, egress_source.tdata});
            eg_cyc.push_back(cyc);
        end
    end

    task automatic drive_word(input logic v, input logic [15:0] d, input logic l,
                              input logic acc, input frame_status st,
                              input logic drop, input logic inc);
        ingress_pkt.tvalid = v;
        ingress_pkt.tdata  = d;
        ingress_pkt.tlast  = l;
        ingress_accept     = acc;
        status             = st;
        drop_current       = drop;
        incomplete_frame   = inc;
        @(posedge clk); #1;
        ingress_pkt      = '0;
        ingress_accept   = 1'b0;
        status           = ST_NONE;
        drop_current     = 1'b0;
        incomplete_frame = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (eg_q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic clear_mon();
        eg_q.delete();
        eg_cyc.delete();
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        ingress_pkt      = '0;
        ingress_accept   = 1'b0;
        status           = ST_NONE;
        incomplete_frame = 1'b0;
        drop_current     = 1'b0;
        egress_sink      = '0;
        idle(3);
        checks++; if (egress_source.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", egress_source.tvalid); else passed++;
        checks++; if (egress_source.tdata !== 16'h0) $display("FAIL rst_tdata: got %h want 0000", egress_source.tdata); else passed++;
        checks++; if (egress_source.tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", egress_source.tlast); else passed++;
        checks++; if (almost_full !== 1'b0) $display("FAIL rst_af: got %b want 0", almost_full); else passed++;
        checks++; if (frame_count !== 12'd0) $display("FAIL rst_fc: got %0d want 0", frame_count); else passed++;
        checks++; if (drop_count !== 16'd0) $display("FAIL rst_drop: got %0d want 0", drop_count); else passed++;
        checks++; if (overflow_count !== 16'd0) $display("FAIL rst_ovf: got %0d want 0", overflow_count); else passed++;
        reset = 1'b1;
        idle(2);
        checks++; if (egress_source.tvalid !== 1'b0) $display("FAIL post_rst_tvalid: got %b want 0", egress_source.tvalid); else passed++;
    endtask

    task automatic test_single_frame();
        int nerr = 0;
        int nlast = 0;
        int span;
        clear_mon();
        egress_sink.tready = 1'b1;
        drive_word(1'b1, 16'h5555, 1'b0, 1'b1, ST_PRE, 1'b0, 1'b0);
        drive_word(1'b1, 16'hD5D5, 1'b0, 1'b1, ST_SFD, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++)
            drive_word(1'b1, 16'(16'h1000 + i), (i == 63), 1'b1, ST_PAY, 1'b0, 1'b0);
        checks++; if (frame_count !== 12'd1) $display("FAIL single_fc_commit: got %0d want 1", frame_count); else passed++;
        wait_words(64, 200);
        idle(2);
        checks++; if (eg_q.size() != 64) $display("FAIL single_count: got %0d want 64", eg_q.size()); else passed++;
        for (int i = 0; i < eg_q.size(); i++) begin
            if (eg_q[i] !== {(i == 63), 16'(16'h1000 + i)}) nerr++;
            if (eg_q[i][16]) nlast++;
        end
        checks++; if (nerr != 0) $display("FAIL single_data: got %0d bad words want 0", nerr); else passed++;
        checks++; if (nlast != 1) $display("FAIL single_tlast: got %0d tlast words want 1", nlast); else passed++;
        span = (eg_cyc.size() > 0) ? (eg_cyc[eg_cyc.size()-1] - eg_cyc[0]) : -1;
        checks++; if (span != 63) $display("FAIL single_bubble: got span %0d want 63", span); else passed++;
        checks++; if (frame_count !== 12'd0) $display("FAIL single_fc_done: got %0d want 0", frame_count); else passed++;
    endtask

    task automatic test_drop();
        int nerr = 0;
        clear_mon();
        egress_sink.tready = 1'b1;
        for (int i = 0; i < 40; i++)
            drive_word(1'b1, 16'(16'h2000 + i), (i == 39), 1'b1, ST_PAY, (i == 9), 1'b0);
        idle(5);
        checks++; if (eg_q.size() != 0) $display("FAIL drop_no_egress: got %0d words want 0", eg_q.size()); else passed++;
        checks++; if (dut.wr_ptr_q !== 12'd64) $display("FAIL drop_wrptr: got %0d want 64", dut.wr_ptr_q); else passed++;
        checks++; if (frame_count !== 12'd0) $display("FAIL drop_fc: got %0d want 0", frame_count); else passed++;
        checks++; if (drop_count !== (STATS ? 16'd1 : 16'd0)) $display("FAIL drop_count: got %0d want %0d", drop_count, STATS ? 1 : 0); else passed++;
        for (int i = 0; i < 5; i++)
            drive_word(1'b1, 16'(16'h3000 + i), (i == 4), 1'b1, ST_PAY, 1'b0, 1'b0);
        wait_words(5, 50);
        idle(2);
        checks++; if (eg_q.size() != 5) $display("FAIL drop_next_count: got %0d want 5", eg_q.size()); else passed++;
        for (int i = 0; i < eg_q.size(); i++)
            if (eg_q[i] !== {(i == 4), 16'(16'h3000 + i)}) nerr++;
        checks++; if (nerr != 0) $display("FAIL drop_next_data: got %0d bad words want 0", nerr); else passed++;
    endtask

    task automatic test_incomplete();
        int nerr = 0;
        clear_mon();
        egress_sink.tready = 1'b1;
        for (int i = 0; i < 3; i++)
            drive_word(1'b1, 16'(16'hAB00 + i), 1'b0, 1'b1, ST_DST, 1'b0, 1'b0);
        drive_word(1'b0, 16'h0, 1'b0, 1'b0, ST_NONE, 1'b0, 1'b1);
        idle(3);
        checks++; if (dut.wr_ptr_q !== 12'd69) $display("FAIL inc_wrptr: got %0d want 69", dut.wr_ptr_q); else passed++;
        checks++; if (frame_count !== 12'd0) $display("FAIL inc_fc: got %0d want 0", frame_count); else passed++;
        checks++; if (drop_count !== (STATS ? 16'd2 : 16'd0)) $display("FAIL inc_drop_count: got %0d want %0d", drop_count, STATS ? 2 : 0); else passed++;
        for (int i = 0; i < 2; i++)
            drive_word(1'b1, 16'(16'h3100 + i), (i == 1), 1'b1, ST_PAY, 1'b0, 1'b0);
        wait_words(2, 30);
        idle(2);
        checks++; if (eg_q.size() != 2) $display("FAIL inc_next_count: got %0d want 2", eg_q.size()); else passed++;
        for (int i = 0; i < eg_q.size(); i++)
            if (eg_q[i] !== {(i == 1), 16'(16'h3100 + i)}) nerr++;
        checks++; if (nerr != 0) $display("FAIL inc_next_data: got %0d bad words want 0", nerr); else passed++;
    endtask

    task automatic test_back_to_back();
        int nerr = 0;
        clear_mon();
        egress_sink.tready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive_word(1'b1, 16'(16'h7000 + i), (i == 2), 1'b1, ST_PAY, 1'b0, 1'b0);
        idle(3);
        checks++; if (egress_source.tvalid !== 1'b1) $display("FAIL b2b_tvalid: got %b want 1", egress_source.tvalid); else passed++;
        checks++; if (egress_source.tdata !== 16'h7000) $display("FAIL b2b_head: got %h want 7000", egress_source.tdata); else passed++;
        idle(2);
        checks++; if ({egress_source.tvalid, egress_source.tdata, egress_source.tlast} !== {1'b1, 16'h7000, 1'b0})
            $display("FAIL b2b_stable: got %b/%h/%b want 1/7000/0", egress_source.tvalid, egress_source.tdata, egress_source.tlast);
        else passed++;
        // A drains on edges 1..3 of B's four write edges; A's tlast meets B's commit
        for (int i = 0; i < 4; i++) begin
            if (i == 1) egress_sink.tready = 1'b1;
            drive_word(1'b1, 16'(16'h7100 + i), (i == 3), 1'b1, ST_PAY, 1'b0, 1'b0);
        end
        checks++; if (frame_count !== 12'd1) $display("FAIL b2b_fc_coincide: got %0d want 1", frame_count); else passed++;
        wait_words(7, 40);
        idle(2);
        checks++; if (eg_q.size() != 7) $display("FAIL b2b_count: got %0d want 7", eg_q.size()); else passed++;
        for (int i = 0; i < eg_q.size(); i++) begin
            if (i < 3) begin
                if (eg_q[i] !== {(i == 2), 16'(16'h7000 + i)}) nerr++;
            end else begin
                if (eg_q[i] !== {(i == 6), 16'(16'h7100 + i - 3)}) nerr++;
            end
        end
        checks++; if (nerr != 0) $display("FAIL b2b_data: got %0d bad words want 0", nerr); else passed++;
        checks++; if (frame_count !== 12'd0) $display("FAIL b2b_fc_done: got %0d want 0", frame_count); else passed++;
    endtask

    task automatic test_almost_full_overflow();
        int nerr = 0;
        int nlast = 0;
        clear_mon();
        egress_sink.tready = 1'b0;
        for (int i = 0; i < 1000; i++)
            drive_word(1'b1, 16'(16'h4000 + i), (i == 999), 1'b1, ST_PAY, 1'b0, 1'b0);
        for (int i = 0; i < 280; i++)
            drive_word(1'b1, 16'(16'h8000 + i), 1'b0, 1'b1, ST_PAY, 1'b0, 1'b0);
        checks++; if (almost_full !== 1'b0) $display("FAIL af_1280: got %b want 0", almost_full); else passed++;
        drive_word(1'b1, 16'(16'h8000 + 280), 1'b0, 1'b1, ST_PAY, 1'b0, 1'b0);
        checks++; if (almost_full !== 1'b0) $display("FAIL af_latency: got %b want 0", almost_full); else passed++;
        idle(1);
        checks++; if (almost_full !== 1'b1) $display("FAIL af_1281: got %b want 1", almost_full); else passed++;
        for (int i = 281; i < 1052; i++)
            drive_word(1'b1, 16'(16'h8000 + i), (i == 1051), 1'b1, ST_PAY, 1'b0, 1'b0);
        idle(2);
        checks++; if (almost_full !== 1'b0) $display("FAIL af_after_ovf: got %b want 0", almost_full); else passed++;
        checks++; if (frame_count !== 12'd1) $display("FAIL ovf_fc: got %0d want 1", frame_count); else passed++;
        checks++; if (overflow_count !== (STATS ? 16'd1 : 16'd0)) $display("FAIL ovf_count: got %0d want %0d", overflow_count, STATS ? 1 : 0); else passed++;
        egress_sink.tready = 1'b1;
        wait_words(1000, 1300);
        idle(20);
        checks++; if (eg_q.size() != 1000) $display("FAIL ovf_drain_count: got %0d want 1000", eg_q.size()); else passed++;
        for (int i = 0; i < eg_q.size(); i++) begin
            if (eg_q[i][15:0] !== 16'(16'h4000 + i)) nerr++;
            if (eg_q[i][16]) nlast++;
        end
        checks++; if (nerr != 0) $display("FAIL ovf_drain_data: got %0d bad words want 0", nerr); else passed++;
        checks++; if (nlast != 1) $display("FAIL ovf_drain_tlast: got %0d tlast words want 1", nlast); else passed++;
        checks++; if (frame_count !== 12'd0) $display("FAIL ovf_fc_done: got %0d want 0", frame_count); else passed++;
    endtask

    task automatic test_reset_midframe();
        int nerr = 0;
        clear_mon();
        egress_sink.tready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive_word(1'b1, 16'(16'h5000 + i), (i == 2), 1'b1, ST_PAY, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive_word(1'b1, 16'(16'h5100 + i), (i == 2), 1'b1, ST_PAY, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)
            drive_word(1'b1, 16'(16'h5200 + i), 1'b0, 1'b1, ST_PAY, 1'b0, 1'b0);
        idle(3);
        checks++; if (frame_count !== 12'd2) $display("FAIL rm_fc_before: got %0d want 2", frame_count); else passed++;
        checks++; if (egress_source.tvalid !== 1'b1) $display("FAIL rm_tvalid_before: got %b want 1", egress_source.tvalid); else passed++;
        reset = 1'b0;
        #2;
        checks++; if (egress_source.tvalid !== 1'b0) $display("FAIL rm_tvalid_async: got %b want 0", egress_source.tvalid); else passed++;
        checks++; if (frame_count !== 12'd0) $display("FAIL rm_fc_async: got %0d want 0", frame_count); else passed++;
        checks++; if (overflow_count !== 16'd0) $display("FAIL rm_ovf_cleared: got %0d want 0", overflow_count); else passed++;
        idle(2);
        reset = 1'b1;
        clear_mon();
        egress_sink.tready = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++)
            drive_word(1'b1, 16'(16'h6000 + i), (i == 3), 1'b1, ST_PAY, 1'b0, 1'b0);
        wait_words(4, 40);
        idle(10);
        checks++; if (eg_q.size() != 4) $display("FAIL rm_after_count: got %0d want 4", eg_q.size()); else passed++;
        for (int i = 0; i < eg_q.size(); i++)
            if (eg_q[i] !== {(i == 3), 16'(16'h6000 + i)}) nerr++;
        checks++; if (nerr != 0) $display("FAIL rm_after_data: got %0d bad words want 0", nerr); else passed++;
        checks++; if (frame_count !== 12'd0) $display("FAIL rm_fc_done: got %0d want 0", frame_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_drop();
        test_incomplete();
        test_back_to_back();
        test_almost_full_overflow();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
